// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel divider, h/v counters and a sync/video delay line that keeps
// sync aligned with renderer colour. Optional colour-bar test pattern under VGA_TESTPAT_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned PIPE_LAT = 2,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef VGA_TESTPAT_EN
  input  logic                 test_en,
`endif
  input  logic [3*COLOR_W-1:0] rgb_in,
  output logic                 pix_tick,
  output logic [CNT_W-1:0]     px,
  output logic [CNT_W-1:0]     py,
  output logic                 video_on,
  output logic                 frame_start,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic [3*COLOR_W-1:0] rgb_out
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

`ifdef VGA_TESTPAT_EN
  localparam int unsigned DW = 6;
`else
  localparam int unsigned DW = 3;
`endif

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] px_q, px_d, py_q, py_d;
  logic [31:0]      px_w, py_w;
  logic             hs_raw, vs_raw;
  logic [DW-1:0]    raw, tap;
  logic             tap_hs, tap_vs, tap_vid;
  logic [3*COLOR_W-1:0] color;

  // With CLK_DIV = 1 the divider is stuck at 0 and pix_tick stays high.
  assign pix_tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = pix_tick ? '0 : div_q + 1'b1;
    px_d  = px_q;
    py_d  = py_q;
    if (pix_tick) begin
      if (px_q == H_LAST) begin
        px_d = '0;
        py_d = (py_q == V_LAST) ? '0 : py_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      px_q  <= '0;
      py_q  <= '0;
    end else begin
      div_q <= div_d;
      px_q  <= px_d;
      py_q  <= py_d;
    end
  end

  assign px          = px_q;
  assign py          = py_q;
  assign px_w        = 32'(px_q);
  assign py_w        = 32'(py_q);
  assign video_on    = (px_w < H_ACTIVE) && (py_w < V_ACTIVE);
  assign hs_raw      = (px_w >= HS_START) && (px_w < HS_END);
  assign vs_raw      = (py_w >= VS_START) && (py_w < VS_END);
  assign frame_start = pix_tick && (px_q == H_LAST) && (py_q == V_LAST);

`ifdef VGA_TESTPAT_EN
  logic [2:0] bar_idx, tap_bar;
  assign bar_idx = 3'((px_w * 32'd8) / H_ACTIVE);
  assign raw     = {bar_idx, hs_raw, vs_raw, video_on};
  assign tap_bar = tap[5:3];
  assign color   = test_en ? {{COLOR_W{tap_bar[2]}}, {COLOR_W{tap_bar[1]}},
                              {COLOR_W{tap_bar[0]}}} : rgb_in;
`else
  assign raw     = {hs_raw, vs_raw, video_on};
  assign color   = rgb_in;
`endif

  // Reset flushes the delay line to all-zero, i.e. sync inactive and video blanked.
  if (PIPE_LAT == 0) begin : g_no_pipe
    assign tap = raw;
  end else begin : g_pipe
    logic [DW-1:0] stage_q [PIPE_LAT];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < PIPE_LAT; i++) stage_q[i] <= '0;
      end else if (pix_tick) begin
        stage_q[0] <= raw;
        for (int i = 1; i < PIPE_LAT; i++) stage_q[i] <= stage_q[i-1];
      end
    end
    assign tap = stage_q[PIPE_LAT-1];
  end

  assign {tap_hs, tap_vs, tap_vid} = tap[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      h_sync  <= ~HS_POL;
      v_sync  <= ~VS_POL;
      rgb_out <= '0;
    end else if (pix_tick) begin
      h_sync  <= tap_hs ? HS_POL : ~HS_POL;
      v_sync  <= tap_vs ? VS_POL : ~VS_POL;
      rgb_out <= tap_vid ? color : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-geometry instance checked against a hand-written vector
// table, and a default-geometry instance checked cycle by cycle against a closed-form model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Default geometry instance (A)
  logic        reset_a;
  logic        test_en;
  logic [11:0] rgb_in_a;
  logic        pix_tick_a, video_on_a, frame_start_a, h_sync_a, v_sync_a;
  logic [9:0]  px_a, py_a;
  logic [11:0] rgb_out_a;

  vga_timing_gen dut_a (
    .clk         (clk),
    .reset       (reset_a),
`ifdef VGA_TESTPAT_EN
    .test_en     (test_en),
`endif
    .rgb_in      (rgb_in_a),
    .pix_tick    (pix_tick_a),
    .px          (px_a),
    .py          (py_a),
    .video_on    (video_on_a),
    .frame_start (frame_start_a),
    .h_sync      (h_sync_a),
    .v_sync      (v_sync_a),
    .rgb_out     (rgb_out_a)
  );

  // Tiny geometry instance (B): H 4/1/1/1, V 2/1/1/1, no divider, no delay, HS_POL = 1
  logic        rst_b;
  logic        test_en_b;
  logic [11:0] rgb_in_b;
  logic        pix_tick_b, video_on_b, frame_start_b, h_sync_b, v_sync_b;
  logic [9:0]  px_b, py_b;
  logic [11:0] rgb_out_b;

  vga_timing_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
    .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .CLK_DIV  (1), .PIPE_LAT (0), .HS_POL (1'b1)
  ) dut_b (
    .clk         (clk),
    .reset       (rst_b),
`ifdef VGA_TESTPAT_EN
    .test_en     (test_en_b),
`endif
    .rgb_in      (rgb_in_b),
    .pix_tick    (pix_tick_b),
    .px          (px_b),
    .py          (py_b),
    .video_on    (video_on_b),
    .frame_start (frame_start_b),
    .h_sync      (h_sync_b),
    .v_sync      (v_sync_b),
    .rgb_out     (rgb_out_b)
  );

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 'h%0h, want 'h%0h", name, cyc, act, exp);
    end
  endtask

  // Renderer for A: two pixel ticks of latency, returns {px[3:0], py[3:0], 4'hA}
  logic [11:0] r1 = 12'h000;
  logic [11:0] r2 = 12'h000;
  initial begin
    rgb_in_a = 12'h000;
    forever begin
      @(negedge clk);
      if (pix_tick_a === 1'b1) begin
        rgb_in_a = r2;
        r2       = r1;
        r1       = {px_a[3:0], py_a[3:0], 4'hA};
      end
    end
  end

  // Cycle-by-cycle check of A for ncyc cycles; cycle 0 is the sample right after reset.
  task automatic scan_a(input int unsigned ncyc, input bit tp);
    int unsigned t, pxe, pye, n, pxn, pyn, last_fall, ticks;
    bit          hs_e, vs_e, tick_e, hs_prev, have_fall;
    logic [11:0] rgb_e;
    logic [2:0]  idx;
    hs_prev   = 1'b1;
    have_fall = 1'b0;
    last_fall = 0;
    ticks     = 0;
    for (int unsigned c = 0; c < ncyc; c++) begin
      t      = c / 4;
      pxe    = t % 800;
      pye    = (t / 800) % 525;
      tick_e = (c % 4) == 3;
      hs_e   = 1'b1;
      vs_e   = 1'b1;
      rgb_e  = 12'h000;
      if (t >= 3) begin
        n   = t - 3;
        pxn = n % 800;
        pyn = (n / 800) % 525;
        hs_e = !(pxn >= 656 && pxn <= 751);
        vs_e = !(pyn >= 490 && pyn <= 491);
        if (pxn < 640 && pyn < 480) begin
          idx   = 3'(pxn / 80);
          rgb_e = tp ? {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}}
                     : {4'(pxn), 4'(pyn), 4'hA};
        end
      end
      chk("A px", c, 32'(px_a), pxe);
      chk("A py", c, 32'(py_a), pye);
      chk("A pix_tick", c, 32'(pix_tick_a), 32'(tick_e));
      chk("A video_on", c, 32'(video_on_a), 32'(pxe < 640 && pye < 480));
      chk("A frame_start", c, 32'(frame_start_a), 32'(tick_e && pxe == 799 && pye == 524));
      chk("A h_sync", c, 32'(h_sync_a), 32'(hs_e));
      chk("A v_sync", c, 32'(v_sync_a), 32'(vs_e));
      chk("A rgb_out", c, 32'(rgb_out_a), 32'(rgb_e));
      // Line timing measured directly from the observed h_sync waveform
      if (hs_prev && h_sync_a === 1'b0) begin
        if (have_fall) begin
          chk("A h_sync period", c, c - last_fall, 3200);
          chk("A ticks per line", c, ticks, 800);
        end
        have_fall = 1'b1;
        last_fall = c;
        ticks     = 0;
      end
      if (!hs_prev && h_sync_a === 1'b1) chk("A h_sync low width", c, c - last_fall, 384);
      if (pix_tick_a === 1'b1) ticks++;
      hs_prev = (h_sync_a === 1'b1);
      if (!tp && c == 3252) chk("A rgb pixel (10,1)", c, 32'(rgb_out_a), 32'hA1A);
      if (tp && c == 172)  chk("A bar px 40", c, 32'(rgb_out_a), 32'h000);
      if (tp && c == 412)  chk("A bar px 100", c, 32'(rgb_out_a), 32'h00F);
      if (tp && c == 1212) chk("A bar px 300", c, 32'(rgb_out_a), 32'h0FF);
      if (tp && c == 2412) chk("A bar px 600", c, 32'(rgb_out_a), 32'hFFF);
      if (tp && c == 2812) chk("A bar px 700 blank", c, 32'(rgb_out_a), 32'h000);
      @(negedge clk);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    int unsigned px;
    int unsigned py;
    bit          vid;
    bit          hs;
    bit          vs;
    bit          fs;
    logic [11:0] rgb;
  } vec_t;

  vec_t vb [18];

  initial begin
    int unsigned cur;
    reset_a   = 1'b1;
    rst_b     = 1'b1;
    test_en   = 1'b0;
    test_en_b = 1'b0;
    rgb_in_b  = 12'h5C3;

    //          cyc px py vid hs vs fs rgb
    vb[0]  = '{0,  0, 0, 1, 0, 1, 0, 12'h000};
    vb[1]  = '{1,  1, 0, 1, 0, 1, 0, 12'h5C3};
    vb[2]  = '{4,  4, 0, 0, 0, 1, 0, 12'h5C3};
    vb[3]  = '{5,  5, 0, 0, 0, 1, 0, 12'h000};
    vb[4]  = '{6,  6, 0, 0, 1, 1, 0, 12'h000};
    vb[5]  = '{7,  0, 1, 1, 0, 1, 0, 12'h000};
    vb[6]  = '{8,  1, 1, 1, 0, 1, 0, 12'h5C3};
    vb[7]  = '{13, 6, 1, 0, 1, 1, 0, 12'h000};
    vb[8]  = '{14, 0, 2, 0, 0, 1, 0, 12'h000};
    vb[9]  = '{15, 1, 2, 0, 0, 1, 0, 12'h000};
    vb[10] = '{21, 0, 3, 0, 0, 1, 0, 12'h000};
    vb[11] = '{22, 1, 3, 0, 0, 0, 0, 12'h000};
    vb[12] = '{28, 0, 4, 0, 0, 0, 0, 12'h000};
    vb[13] = '{29, 1, 4, 0, 0, 1, 0, 12'h000};
    vb[14] = '{34, 6, 4, 0, 1, 1, 1, 12'h000};
    vb[15] = '{35, 0, 0, 1, 0, 1, 0, 12'h000};
    vb[16] = '{36, 1, 0, 1, 0, 1, 0, 12'h5C3};
    vb[17] = '{41, 6, 0, 0, 1, 1, 0, 12'h000};

    repeat (3) @(negedge clk);

    // A held in reset
    chk("A reset px", 0, 32'(px_a), 0);
    chk("A reset py", 0, 32'(py_a), 0);
    chk("A reset h_sync", 0, 32'(h_sync_a), 1);
    chk("A reset v_sync", 0, 32'(v_sync_a), 1);
    chk("A reset rgb_out", 0, 32'(rgb_out_a), 0);
    chk("A reset pix_tick", 0, 32'(pix_tick_a), 0);
    chk("A reset frame_start", 0, 32'(frame_start_a), 0);

    // B: table-driven, cycle 0 is this sample
    rst_b = 1'b0;
    cur   = 0;
    foreach (vb[i]) begin
      repeat (vb[i].cyc - cur) @(negedge clk);
      cur = vb[i].cyc;
      chk("B px", int'(cur), 32'(px_b), vb[i].px);
      chk("B py", int'(cur), 32'(py_b), vb[i].py);
      chk("B pix_tick", int'(cur), 32'(pix_tick_b), 1);
      chk("B video_on", int'(cur), 32'(video_on_b), 32'(vb[i].vid));
      chk("B h_sync", int'(cur), 32'(h_sync_b), 32'(vb[i].hs));
      chk("B v_sync", int'(cur), 32'(v_sync_b), 32'(vb[i].vs));
      chk("B frame_start", int'(cur), 32'(frame_start_b), 32'(vb[i].fs));
      chk("B rgb_out", int'(cur), 32'(rgb_out_a === 12'hxxx ? 12'h000 : rgb_out_b),
          32'(vb[i].rgb));
    end

    // A: release, run to px = 300 on line 1 (active video on the outputs)
    @(negedge clk);
    reset_a = 1'b0;
    scan_a(4401, 1'b0);

    // One-clock reset mid-line: counters restart, colour is blanked at once
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    chk("A midreset px", 0, 32'(px_a), 0);
    chk("A midreset py", 0, 32'(py_a), 0);
    chk("A midreset h_sync", 0, 32'(h_sync_a), 1);
    chk("A midreset v_sync", 0, 32'(v_sync_a), 1);
    chk("A midreset rgb_out", 0, 32'(rgb_out_a), 0);
    scan_a(6001, 1'b0);

    // Reset while h_sync is being driven low: the pulse must not continue
    chk("A in sync pulse", 0, 32'(h_sync_a), 0);
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    scan_a(200, 1'b0);

`ifdef VGA_TESTPAT_EN
    reset_a = 1'b1;
    test_en = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    scan_a(3200, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
